// File: rtl/demux_1to8_seq.sv
// ---------------------------------------------------------------------------
// demux_1to8_seq
//   Sequenced 1-to-8 demultiplexer with registered outputs. A serial word
//   stream is routed onto eight held channels, either by an explicit channel
//   select (manual mode) or by an internal scan counter (auto mode). In auto
//   mode a complete frame is presented with frame_valid and is held until
//   frame_ack, after which scanning restarts at channel 0.
//
//   Optional feature macro: DEMUX_OVF_EN
//     defined   -> adds the sticky overflow flag port 'ovf'
//     undefined -> words arriving while a frame is held are silently dropped
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   din         input word (WIDTH bits)
//   din_valid   din is written this cycle if accepted
//   sel         target channel in manual mode
//   auto_en     1 = auto-scan, 0 = manual
//   frame_ack   consumer accepts the held frame
//   y           eight channels, channel k = y[k*WIDTH +: WIDTH]
//   frame_valid auto mode: all 8 channels written, frame held
//   cnt         current auto-scan channel index
//   ovf         sticky overflow (DEMUX_OVF_EN only)
// ---------------------------------------------------------------------------
module demux_1to8_seq #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   din,
    input  logic               din_valid,
    input  logic [2:0]         sel,
    input  logic               auto_en,
    input  logic               frame_ack,
    output logic [8*WIDTH-1:0] y,
    output logic               frame_valid,
    output logic [2:0]         cnt
`ifdef DEMUX_OVF_EN
    ,
    output logic               ovf
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            y           <= '0;
            cnt         <= 3'd0;
            frame_valid <= 1'b0;
`ifdef DEMUX_OVF_EN
            ovf         <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // The entry cycle into auto mode still honours a manual write.
                    if (din_valid)
                        y[sel*WIDTH +: WIDTH] <= din;
                    if (auto_en) begin
                        state <= FILL;
                        cnt   <= 3'd0;
                    end
                end

                FILL: begin
                    if (!auto_en) begin
                        // Leaving auto mode: a same-cycle word is treated as manual.
                        state       <= IDLE;
                        cnt         <= 3'd0;
                        frame_valid <= 1'b0;
                        if (din_valid)
                            y[sel*WIDTH +: WIDTH] <= din;
                    end else if (din_valid) begin
                        y[cnt*WIDTH +: WIDTH] <= din;
                        if (cnt == 3'd7) begin
                            // Last channel written: hold the frame, scan index restarts.
                            state       <= FULL;
                            frame_valid <= 1'b1;
                            cnt         <= 3'd0;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end

                FULL: begin
                    if (!auto_en) begin
                        state       <= IDLE;
                        cnt         <= 3'd0;
                        frame_valid <= 1'b0;
                        if (din_valid)
                            y[sel*WIDTH +: WIDTH] <= din;
                    end else if (frame_ack) begin
                        // Ack releases the frame; a word in the same cycle starts
                        // the next frame at channel 0.
                        state       <= FILL;
                        frame_valid <= 1'b0;
                        if (din_valid) begin
                            y[WIDTH-1:0] <= din;
                            cnt          <= 3'd1;
                        end else begin
                            cnt <= 3'd0;
                        end
                    end else if (din_valid) begin
                        // Frame is frozen; the word is dropped.
`ifdef DEMUX_OVF_EN
                        ovf <= 1'b1;
`endif
                    end
                end

                default: begin
                    state       <= IDLE;
                    cnt         <= 3'd0;
                    frame_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_1to8_seq.sv
module tb_demux_1to8_seq;

    localparam int WIDTH = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [WIDTH-1:0]   din = '0;
    logic               din_valid = 1'b0;
    logic [2:0]         sel = 3'd0;
    logic               auto_en = 1'b0;
    logic               frame_ack = 1'b0;
    logic [8*WIDTH-1:0] y;
    logic               frame_valid;
    logic [2:0]         cnt;
`ifdef DEMUX_OVF_EN
    logic               ovf;
`endif

    int checks = 0;
    int errors = 0;

    demux_1to8_seq #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sel        (sel),
        .auto_en    (auto_en),
        .frame_ack  (frame_ack),
        .y          (y),
        .frame_valid(frame_valid),
        .cnt        (cnt)
`ifdef DEMUX_OVF_EN
        ,
        .ovf        (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        checks++;
        if (y !== 32'h0 || cnt !== 3'd0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: y=%h cnt=%0d fv=%b, want y=0 cnt=0 fv=0", y, cnt, frame_valid);
        end
        rst = 1'b0;
        auto_en = 1'b1;
        step();
        din_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            din = 4'(k + 1);
            step();
        end
        din_valid = 1'b0;
        checks++;
        if (cnt !== 3'd5 || y !== 32'h00054321) begin
            errors++;
            $display("FAIL reset_prefill: cnt=%0d y=%h, want cnt=5 y=00054321", cnt, y);
        end
        // Assert reset between edges; the clear must be visible before the next edge.
        rst = 1'b1;
        #2;
        checks++;
        if (y !== 32'h0 || cnt !== 3'd0 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: y=%h cnt=%0d fv=%b, want y=0 cnt=0 fv=0", y, cnt, frame_valid);
        end
        auto_en = 1'b0;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_manual();
        sel = 3'd3; din = 4'hA; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        checks++;
        if (y !== 32'h0000A000) begin
            errors++;
            $display("FAIL manual_sel3: y=%h, want 0000a000", y);
        end
        din = 4'h7;
        step();
        checks++;
        if (y !== 32'h0000A000) begin
            errors++;
            $display("FAIL manual_hold: y=%h, want 0000a000", y);
        end
        sel = 3'd7; din = 4'h5; din_valid = 1'b1;
        step();
        sel = 3'd0; din = 4'hF;
        frame_ack = 1'b1;  // ignored outside FULL
        step();
        din_valid = 1'b0; frame_ack = 1'b0;
        checks++;
        if (y !== 32'h5000A00F || frame_valid !== 1'b0 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL manual_edges: y=%h fv=%b cnt=%0d, want 5000a00f 0 0", y, frame_valid, cnt);
        end
    endtask

    task automatic test_auto_fill();
        auto_en = 1'b1;
        step();
        din_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            din = 4'(k + 1);
            step();
        end
        checks++;
        if (cnt !== 3'd7 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL auto_seven: cnt=%0d fv=%b, want 7 0", cnt, frame_valid);
        end
        din = 4'h8;
        step();
        din_valid = 1'b0;
        checks++;
        if (y !== 32'h87654321 || frame_valid !== 1'b1 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL auto_full: y=%h fv=%b cnt=%0d, want 87654321 1 0", y, frame_valid, cnt);
        end
    endtask

    task automatic test_full_ack();
        din = 4'hE; din_valid = 1'b1; frame_ack = 1'b0;
        step();
        checks++;
        if (y !== 32'h87654321 || frame_valid !== 1'b1 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL full_drop: y=%h fv=%b cnt=%0d, want 87654321 1 0", y, frame_valid, cnt);
        end
`ifdef DEMUX_OVF_EN
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL full_ovf: ovf=%b, want 1", ovf);
        end
`endif
        din = 4'h9; frame_ack = 1'b1;
        step();
        din_valid = 1'b0; frame_ack = 1'b0;
        checks++;
        if (y !== 32'h87654329 || frame_valid !== 1'b0 || cnt !== 3'd1) begin
            errors++;
            $display("FAIL full_ack: y=%h fv=%b cnt=%0d, want 87654329 0 1", y, frame_valid, cnt);
        end
    endtask

    task automatic test_auto_drop();
        din_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din = 4'(10 + k);
            step();
        end
        din_valid = 1'b0;
        checks++;
        if (cnt !== 3'd4 || y !== 32'h8765CBA9) begin
            errors++;
            $display("FAIL drop_prep: cnt=%0d y=%h, want 4 8765cba9", cnt, y);
        end
        auto_en = 1'b0;
        step();
        checks++;
        if (cnt !== 3'd0 || frame_valid !== 1'b0 || y !== 32'h8765CBA9) begin
            errors++;
            $display("FAIL drop_idle: cnt=%0d fv=%b y=%h, want 0 0 8765cba9", cnt, frame_valid, y);
        end
        sel = 3'd5; din = 4'h0; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        checks++;
        if (y !== 32'h8705CBA9 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL drop_manual: y=%h cnt=%0d, want 8705cba9 0", y, cnt);
        end
    endtask

    task automatic test_auto_entry();
        // Entering auto mode with a word present writes it to sel.
        sel = 3'd6; din = 4'h1; din_valid = 1'b1; auto_en = 1'b1;
        step();
        checks++;
        if (y !== 32'h8105CBA9 || cnt !== 3'd0) begin
            errors++;
            $display("FAIL entry_write: y=%h cnt=%0d, want 8105cba9 0", y, cnt);
        end
        din = 4'h2;
        step();
        din_valid = 1'b0;
        checks++;
        if (y !== 32'h8105CBA2 || cnt !== 3'd1) begin
            errors++;
            $display("FAIL entry_scan: y=%h cnt=%0d, want 8105cba2 1", y, cnt);
        end
        auto_en = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto_fill();
        test_full_ack();
        test_auto_drop();
        test_auto_entry();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
